ber_sweep_ctrl: RTL and testbench
=================================

# ber_sweep_ctrl

Test sequencer that drives the `transmitor` datapath through a sweep of channel BER settings. For each step it:
- pulses `init_tab`,
- lets the chain settle,
- enables transmission for a fixed number of decoded bits,
- counts decoder bit errors against a reference stream,
- hands one result record per step to a downstream reporter over a valid/ready handshake.

It sits between the experiment top level (start/range control) and the `transmitor` instance (`init_tab`, `BER`, `IsTransmit`, `decoder_out`).

## Interface
Parameters:
- `FRAME_BITS`, 1024: decoded bits compared per BER step (≥1).
- `SETTLE_CYC`, 4: idle cycles between the `init_tab` pulse and transmit enable (≥1).
- `TIMEOUT_CYC`, 4096: max cycles in RUN without `bit_valid` before the step is aborted.
- `CNT_W`, 16: width of the bit and error counters; must hold `FRAME_BITS`.

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle sweep request; sampled only in IDLE.
- `ber_first` in 4: first BER code of the sweep; sampled with `start`.
- `ber_last` in 4: last BER code of the sweep; sampled with `start`.
- `init_tab` out 1: one-cycle table-init pulse to the transmitor.
- `ber` out 4: current BER code to the transmitor.
- `is_transmit` out 1: transmit enable to the transmitor.
- `bit_valid` in 1: strobe; `decoder_out`/`ref_bit` are valid this cycle.
- `decoder_out` in 1: decoded bit from the transmitor.
- `ref_bit` in 1: expected (source) bit aligned with `decoder_out`.
- `res_valid` out 1: result record available.
- `res_ready` in 1: downstream accepts the record.
- `res_ber` out 4: BER code of the record.
- `res_err` out `CNT_W`: error count, saturating.
- `res_bits` out `CNT_W`: bits compared.
- `res_timeout` out 1: the step was aborted by the watchdog.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the sweep completes.

## Operation
- States: IDLE, INIT, SETTLE, RUN, REPORT.
- IDLE → INIT on `start`.
  - Latch the range; `ber` := `ber_first`.
  - If `ber_first` > `ber_last`, the sweep is a single step at `ber_first`.
- INIT (exactly 1 cycle): `init_tab`=1; clear the bit counter, error counter, timeout flag and watchdog. → SETTLE.
- SETTLE: count `SETTLE_CYC` cycles with `is_transmit`=0. → RUN.
- RUN: `is_transmit`=1. On each `bit_valid`:
  - bits += 1;
  - err += (`decoder_out` != `ref_bit`), saturating at all-ones;
  - watchdog cleared.
  - Without `bit_valid`, the watchdog increments.
  - → REPORT when the bit count reaches `FRAME_BITS`, counting the strobe in the current cycle.
  - → REPORT with `res_timeout`=1 when the watchdog reaches `TIMEOUT_CYC`.
- REPORT: `res_valid`=1. `res_*` are held stable until `res_valid && res_ready`. On that handshake:
  - if `ber` == `ber_last` or single-step: `done` pulses and the state returns to IDLE;
  - else `ber` += 1 and → INIT.
- `bit_valid` outside RUN is ignored. `start` while busy is ignored.
- Reset mid-sweep aborts immediately. No partial record is emitted.

## Timing
- Reset values: `init_tab`=0, `ber`=0, `is_transmit`=0, `res_valid`=0, `res_ber`=0, `res_err`=0, `res_bits`=0, `res_timeout`=0, `busy`=0, `done`=0. State = IDLE.
- All outputs are registered.
- `start` sampled at edge t:
  - `init_tab`=1 during cycle t+1;
  - `is_transmit` rises at t+2+`SETTLE_CYC`.
- Frame completion: the last strobe is counted at edge k. In cycle k+1, `is_transmit`=0 and `res_valid`=1.
- `ber` is updated on the same edge `init_tab` rises and holds until the next step's INIT.
- `res_ready` may be high before `res_valid`; the record is then consumed in its first valid cycle.
- `done` coincides with the cycle after the final handshake; `busy` falls in the same cycle.
- Minimum step period with ready always high: 1 + `SETTLE_CYC` + `FRAME_BITS`(if `bit_valid` every cycle) + 1 cycles.

## Structure
- Shared package `ber_sweep_pkg`:
  - state enum (IDLE/INIT/SETTLE/RUN/REPORT);
  - `BER_W`=4;
  - the result record struct (ber, err, bits, timeout).
- One sub-module, `ber_err_counter`:
  - bit counter and saturating error counter with clear, strobe and compare inputs;
  - exposes a `frame_full` flag.
- FSM, settle counter and watchdog live in the top.

## Test plan
- Sweep 2→4, `FRAME_BITS`=16, `bit_valid` every cycle, `ref_bit`=`decoder_out`, ready high:
  - required: three records, `ber`=2,3,4, `err`=0, `bits`=16, `res_timeout`=0;
  - required: 3 `init_tab` pulses, 1 `done`.
- Decoder output inverted on every 4th strobe, `FRAME_BITS`=16: `res_err`=4 per record.
- `ber_first`=7, `ber_last`=3: required: exactly one record with `res_ber`=7, then `done`.
- `bit_valid` stops after 5 bits, `TIMEOUT_CYC`=8:
  - required: record with `res_bits`=5, `res_timeout`=1;
  - required: the sweep continues to the next BER.
- `res_ready` held low 10 cycles in REPORT: `res_*` stable, `is_transmit`=0, `ber` unchanged; the handshake then advances the sweep.
- Reset asserted during RUN of step 2: outputs immediately at reset values, no `done`; a new `start` then restarts cleanly from `ber_first`.

Source files
------------

// File: rtl/ber_sweep_pkg.sv
// Shared types and constants for the BER sweep sequencer.
package ber_sweep_pkg;

    localparam int unsigned BER_W = 4;
    localparam int unsigned REC_CNT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StSettle,
        StRun,
        StReport
    } state_e;

    // One result record per BER step as seen by the reporter.
    typedef struct packed {
        logic [BER_W-1:0]     ber;
        logic [REC_CNT_W-1:0] err;
        logic [REC_CNT_W-1:0] bits;
        logic                 timeout;
    } result_t;

endpackage

// File: rtl/ber_err_counter.sv
// Bit counter and saturating bit-error counter for one BER step.
module ber_err_counter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FRAME_BITS = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             strobe_i,
    input  logic             mismatch_i,
    output logic [CNT_W-1:0] bits_o,       // count including this cycle's strobe
    output logic [CNT_W-1:0] err_o,        // count including this cycle's strobe
    output logic             frame_full_o  // this strobe completes the frame
);

    logic [CNT_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] err_q, err_d;

    // Next-state counts; clear wins over a strobe.
    always_comb begin
        bits_d = bits_q;
        err_d  = err_q;
        if (clr_i) begin
            bits_d = '0;
            err_d  = '0;
        end else if (strobe_i) begin
            bits_d = bits_q + CNT_W'(1);
            if (mismatch_i && (err_q != {CNT_W{1'b1}})) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q <= '0;
            err_q  <= '0;
        end else begin
            bits_q <= bits_d;
            err_q  <= err_d;
        end
    end

    assign bits_o       = bits_d;
    assign err_o        = err_d;
    assign frame_full_o = !clr_i && strobe_i && (bits_q == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/ber_sweep_ctrl.sv
// Sequencer sweeping the transmitor through a range of BER codes and reporting error counts.
module ber_sweep_ctrl
    import ber_sweep_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = 1024,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BER_W-1:0] ber_first,
    input  logic [BER_W-1:0] ber_last,
    output logic             init_tab,
    output logic [BER_W-1:0] ber,
    output logic             is_transmit,
    input  logic             bit_valid,
    input  logic             decoder_out,
    input  logic             ref_bit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [BER_W-1:0] res_ber,
    output logic [CNT_W-1:0] res_err,
    output logic [CNT_W-1:0] res_bits,
    output logic             res_timeout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

    state_e           state_q, state_d;
    logic [BER_W-1:0] ber_q, ber_d;
    logic [BER_W-1:0] ber_last_q, ber_last_d;
    logic             single_q, single_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             init_tab_q, init_tab_d;
    logic             is_transmit_q, is_transmit_d;
    logic             res_valid_q, res_valid_d;
    logic [BER_W-1:0] res_ber_q, res_ber_d;
    logic [CNT_W-1:0] res_err_q, res_err_d;
    logic [CNT_W-1:0] res_bits_q, res_bits_d;
    logic             res_timeout_q, res_timeout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_clr;
    logic             cnt_strobe;
    logic [CNT_W-1:0] cnt_bits;
    logic [CNT_W-1:0] cnt_err;
    logic             frame_full;

    assign cnt_clr    = (state_q == StInit);
    assign cnt_strobe = (state_q == StRun) && bit_valid;

    ber_err_counter #(
        .CNT_W      (CNT_W),
        .FRAME_BITS (FRAME_BITS)
    ) u_err_counter (
        .clk_i        (sys_clk),
        .rst_i        (reset),
        .clr_i        (cnt_clr),
        .strobe_i     (cnt_strobe),
        .mismatch_i   (decoder_out != ref_bit),
        .bits_o       (cnt_bits),
        .err_o        (cnt_err),
        .frame_full_o (frame_full)
    );

    // Next-state logic; outputs are decoded from the next state so they leave a register.
    always_comb begin
        state_d       = state_q;
        ber_d         = ber_q;
        ber_last_d    = ber_last_q;
        single_d      = single_q;
        set_cnt_d     = set_cnt_q;
        wd_d          = wd_q;
        res_ber_d     = res_ber_q;
        res_err_d     = res_err_q;
        res_bits_d    = res_bits_q;
        res_timeout_d = res_timeout_q;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ber_d      = ber_first;
                    ber_last_d = ber_last;
                    single_d   = (ber_first > ber_last);
                    state_d    = StInit;
                end
            end
            StInit: begin
                set_cnt_d = '0;
                wd_d      = '0;
                state_d   = StSettle;
            end
            StSettle: begin
                if (set_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d = StRun;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            StRun: begin
                if (bit_valid) begin
                    wd_d = '0;
                    if (frame_full) begin
                        res_ber_d     = ber_q;
                        res_err_d     = cnt_err;
                        res_bits_d    = cnt_bits;
                        res_timeout_d = 1'b0;
                        state_d       = StReport;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        res_ber_d     = ber_q;
                        res_err_d     = cnt_err;
                        res_bits_d    = cnt_bits;
                        res_timeout_d = 1'b1;
                        state_d       = StReport;
                    end
                end
            end
            StReport: begin
                if (res_ready) begin
                    if (single_q || (ber_q == ber_last_q)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ber_d   = ber_q + BER_W'(1);
                        state_d = StInit;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        init_tab_d    = (state_d == StInit);
        is_transmit_d = (state_d == StRun);
        res_valid_d   = (state_d == StReport);
        busy_d        = (state_d != StIdle);
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ber_q         <= '0;
            ber_last_q    <= '0;
            single_q      <= 1'b0;
            set_cnt_q     <= '0;
            wd_q          <= '0;
            init_tab_q    <= 1'b0;
            is_transmit_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ber_q     <= '0;
            res_err_q     <= '0;
            res_bits_q    <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ber_q         <= ber_d;
            ber_last_q    <= ber_last_d;
            single_q      <= single_d;
            set_cnt_q     <= set_cnt_d;
            wd_q          <= wd_d;
            init_tab_q    <= init_tab_d;
            is_transmit_q <= is_transmit_d;
            res_valid_q   <= res_valid_d;
            res_ber_q     <= res_ber_d;
            res_err_q     <= res_err_d;
            res_bits_q    <= res_bits_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign init_tab    = init_tab_q;
    assign ber         = ber_q;
    assign is_transmit = is_transmit_q;
    assign res_valid   = res_valid_q;
    assign res_ber     = res_ber_q;
    assign res_err     = res_err_q;
    assign res_bits    = res_bits_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Self-checking bench for ber_sweep_ctrl with randomized bit streams and a sweep-level model.
module tb_ber_sweep_ctrl;

    localparam int FB = 16;
    localparam int SC = 4;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    ber_first;
    logic [3:0]    ber_last;
    logic          init_tab;
    logic [3:0]    ber;
    logic          is_transmit;
    logic          bit_valid;
    logic          decoder_out;
    logic          ref_bit;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_ber;
    logic [CW-1:0] res_err;
    logic [CW-1:0] res_bits;
    logic          res_timeout;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int n_init = 0;
    int n_done = 0;

    wire [45:0] all_out = {init_tab, ber, is_transmit, res_valid, res_ber, res_err, res_bits,
                           res_timeout, busy, done};

    ber_sweep_ctrl #(
        .FRAME_BITS  (FB),
        .SETTLE_CYC  (SC),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .start       (start),
        .ber_first   (ber_first),
        .ber_last    (ber_last),
        .init_tab    (init_tab),
        .ber         (ber),
        .is_transmit (is_transmit),
        .bit_valid   (bit_valid),
        .decoder_out (decoder_out),
        .ref_bit     (ref_bit),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ber     (res_ber),
        .res_err     (res_err),
        .res_bits    (res_bits),
        .res_timeout (res_timeout),
        .busy        (busy),
        .done        (done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (init_tab === 1'b1) n_init++;
        if (done === 1'b1) n_done++;
    end

    // One BER step: init, settle, frame (or early stop), report with optional back-pressure.
    task automatic do_step(input logic [3:0] exp_ber, input int mode, input int n_bits,
                           input int bp, input bit last, input bit poke);
        int         exp_err;
        int         n;
        int         cyc;
        int         zeros;
        logic       mis;
        logic       vld;
        logic [36:0] snap;
        exp_err = 0;
        n = 0;
        cyc = 0;
        zeros = 0;
        res_ready = (bp == 0);
        for (int i = 0; i < 40 && init_tab !== 1'b1; i++) @(negedge sys_clk);
        checks++;
        if (init_tab !== 1'b1) begin
            errors++;
            $display("FAIL init_pulse: init_tab=%b required 1", init_tab);
        end
        checks++;
        if (ber !== exp_ber) begin
            errors++;
            $display("FAIL step_ber: ber=%0d required %0d", ber, exp_ber);
        end
        // Strobes during settle must be ignored.
        bit_valid = 1'b1;
        decoder_out = 1'b1;
        ref_bit = 1'b0;
        while (is_transmit !== 1'b1 && cyc < 40) begin
            @(negedge sys_clk);
            cyc++;
        end
        checks++;
        if (cyc != SC + 1) begin
            errors++;
            $display("FAIL settle_len: cycles=%0d required %0d", cyc, SC + 1);
        end
        while (n < n_bits) begin
            vld = (mode != 2) || (zeros >= 3) || ($urandom_range(0, 3) != 0);
            mis = 1'b0;
            if (vld) begin
                if (mode == 1) mis = ((n % 4) == 3);
                else if (mode == 2) mis = 1'($urandom_range(0, 1));
                decoder_out = 1'($urandom_range(0, 1));
                ref_bit = decoder_out ^ mis;
                exp_err += int'(mis);
                n++;
                zeros = 0;
            end else begin
                zeros++;
            end
            bit_valid = vld;
            if (poke && n == 1 && vld) begin
                start = 1'b1;
                ber_first = 4'hf;
            end
            @(negedge sys_clk);
            start = 1'b0;
            if (n < n_bits) begin
                checks++;
                if (is_transmit !== 1'b1 || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL run_hold: is_transmit=%b res_valid=%b required 1/0",
                             is_transmit, res_valid);
                end
            end
        end
        bit_valid = 1'b0;
        if (n_bits < FB) begin
            repeat (TO - 1) @(negedge sys_clk);
            checks++;
            if (res_valid !== 1'b0 || is_transmit !== 1'b1) begin
                errors++;
                $display("FAIL timeout_early: res_valid=%b is_transmit=%b required 0/1",
                         res_valid, is_transmit);
            end
            @(negedge sys_clk);
        end
        checks++;
        if (res_valid !== 1'b1 || is_transmit !== 1'b0) begin
            errors++;
            $display("FAIL report_entry: res_valid=%b is_transmit=%b required 1/0",
                     res_valid, is_transmit);
        end
        checks++;
        if (res_ber !== exp_ber) begin
            errors++;
            $display("FAIL res_ber: got %0d required %0d", res_ber, exp_ber);
        end
        checks++;
        if (res_err !== CW'(exp_err)) begin
            errors++;
            $display("FAIL res_err: got %0d required %0d", res_err, exp_err);
        end
        checks++;
        if (res_bits !== CW'(n_bits)) begin
            errors++;
            $display("FAIL res_bits: got %0d required %0d", res_bits, n_bits);
        end
        checks++;
        if (res_timeout !== (n_bits < FB)) begin
            errors++;
            $display("FAIL res_timeout: got %b required %b", res_timeout, n_bits < FB);
        end
        snap = {res_ber, res_err, res_bits, res_timeout};
        // Strobes during report must not disturb the record.
        bit_valid = 1'b1;
        decoder_out = 1'b1;
        ref_bit = 1'b0;
        repeat (bp) begin
            @(negedge sys_clk);
            checks++;
            if ({res_ber, res_err, res_bits, res_timeout} !== snap || res_valid !== 1'b1 ||
                is_transmit !== 1'b0 || ber !== exp_ber) begin
                errors++;
                $display("FAIL hold_record: rec=%h valid=%b tx=%b ber=%0d required %h 1 0 %0d",
                         {res_ber, res_err, res_bits, res_timeout}, res_valid, is_transmit,
                         ber, snap, exp_ber);
            end
        end
        res_ready = 1'b1;
        @(negedge sys_clk);
        bit_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || done !== last || busy !== !last || init_tab !== !last) begin
            errors++;
            $display("FAIL handshake: valid=%b done=%b busy=%b init=%b required 0 %b %b %b",
                     res_valid, done, busy, init_tab, last, !last, !last);
        end
        if (last) begin
            @(negedge sys_clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%b required 0", done);
            end
        end
    endtask

    // Whole sweep; the model derives the step list from the range rules.
    task automatic run_sweep(input logic [3:0] first, input logic [3:0] last, input int mode,
                             input int to_step, input int bp_step, input bit poke);
        int nsteps;
        int ni0;
        int nd0;
        nsteps = (first > last) ? 1 : int'(last) - int'(first) + 1;
        ni0 = n_init;
        nd0 = n_done;
        ber_first = first;
        ber_last = last;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int k = 0; k < nsteps; k++) begin
            do_step(first + 4'(k), mode, (k == to_step) ? 5 : FB, (k == bp_step) ? 10 : 0,
                    k == nsteps - 1, poke && k == 0);
        end
        @(negedge sys_clk);
        checks++;
        if (n_init - ni0 != nsteps) begin
            errors++;
            $display("FAIL init_count: got %0d required %0d", n_init - ni0, nsteps);
        end
        checks++;
        if (n_done - nd0 != 1) begin
            errors++;
            $display("FAIL done_count: got %0d required 1", n_done - nd0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        checks++;
        if (all_out !== 46'd0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h required 0", all_out);
        end
        reset = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (all_out !== 46'd0) begin
            errors++;
            $display("FAIL idle_state: outputs=%h required 0", all_out);
        end
    endtask

    task automatic test_clean_sweep();
        run_sweep(4'd2, 4'd4, 0, -1, -1, 1'b1);
    endtask

    task automatic test_err_pattern();
        run_sweep(4'd5, 4'd6, 1, -1, -1, 1'b0);
    endtask

    task automatic test_single_step();
        run_sweep(4'd7, 4'd3, 0, -1, -1, 1'b0);
    endtask

    task automatic test_timeout();
        run_sweep(4'd9, 4'd10, 0, 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_sweep(4'd11, 4'd12, 2, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] f;
        logic [3:0] l;
        for (int i = 0; i < 3; i++) begin
            f = 4'($urandom_range(0, 15));
            l = (f > 4'd13) ? 4'd15 : f + 4'($urandom_range(0, 2));
            run_sweep(f, l, 2, -1, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        int nd0;
        ber_first = 4'd1;
        ber_last = 4'd3;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        do_step(4'd1, 0, FB, 0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && is_transmit !== 1'b1; i++) @(negedge sys_clk);
        checks++;
        if (is_transmit !== 1'b1 || ber !== 4'd2) begin
            errors++;
            $display("FAIL step2_run: is_transmit=%b ber=%0d required 1 2", is_transmit, ber);
        end
        bit_valid = 1'b1;
        repeat (3) @(negedge sys_clk);
        nd0 = n_done;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_out !== 46'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h required 0", all_out);
        end
        bit_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (n_done != nd0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: done_count=%0d busy=%b valid=%b required %0d 0 0",
                     n_done, busy, res_valid, nd0);
        end
        run_sweep(4'd1, 4'd2, 0, -1, -1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ber_first = '0;
        ber_last = '0;
        bit_valid = 1'b0;
        decoder_out = 1'b0;
        ref_bit = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_clean_sweep();
        test_err_pattern();
        test_single_step();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
